// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared definitions for the UART command parser: command codes, FSM encoding
// and the fixed register-file slots that receive ALU operands.
package uart_rx_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_ALU_OPA,
    ST_ALU_OPB,
    ST_ALU_FUN
  } state_e;

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Byte stream in from UART_RX and register-file/ALU strobes out.
// slave = command parser, master = byte source / strobe consumer.
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_D_VLD;
  logic              RF_WrEn;
  logic              RF_RdEn;
  logic [ADDR_W-1:0] RF_Address;
  logic [DATA_W-1:0] RF_WrData;
  logic              ALU_EN;
  logic [FUN_W-1:0]  ALU_FUN;
  logic              BUSY;
  logic              CMD_ERR;

  modport master (
    output RX_P_DATA, RX_D_VLD,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, BUSY, CMD_ERR
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, BUSY, CMD_ERR
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl_timeout_cnt.sv
// Inter-byte idle counter: clears on each byte or when not busy, expires after
// TIMEOUT_CYCLES silent busy cycles. Only used when CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en & ~i_clr & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Expiry also clears so the first IDLE cycle already sees a zero count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_cnt <= '0;
    else if (i_clr | ~i_en | o_expire) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Parses UART command frames into single-cycle RF write/read and ALU strobes.
// Optional inter-byte timeout abort: define CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl
  import uart_rx_cmd_ctrl_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int FUN_W          = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic               CLK,
  input  logic               RST,
  uart_rx_cmd_ctrl_if.slave  bus
);

  if (TIMEOUT_CYCLES < 2 || ADDR_W > DATA_W || FUN_W > DATA_W) begin : g_param_chk
    $error("uart_rx_cmd_ctrl: bad parameter combination");
  end

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [ADDR_W-1:0] r_rf_addr, w_rf_addr;
  logic [DATA_W-1:0] r_wr_data, w_wr_data;
  logic [FUN_W-1:0]  r_alu_fun, w_alu_fun;
  logic              r_wr_en, w_wr_en;
  logic              r_rd_en, w_rd_en;
  logic              r_alu_en, w_alu_en;
  logic              r_err, w_err;
  logic              r_busy;
  logic              w_vld;
  logic [DATA_W-1:0] w_byte;
  logic              w_expire;

  assign w_vld  = bus.RX_D_VLD;
  assign w_byte = bus.RX_P_DATA;

`ifdef CMD_TIMEOUT_EN
  uart_cmd_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_clr    (w_vld),
    .i_en     (r_state != ST_IDLE),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_addr    = r_addr;
    w_rf_addr = r_rf_addr;
    w_wr_data = r_wr_data;
    w_alu_fun = r_alu_fun;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_alu_en  = 1'b0;
    w_err     = 1'b0;
    if (w_vld) begin
      case (r_state)
        ST_IDLE: begin
          if      (w_byte == DATA_W'(CMD_RF_WR))   w_next = ST_WR_ADDR;
          else if (w_byte == DATA_W'(CMD_RF_RD))   w_next = ST_RD_ADDR;
          else if (w_byte == DATA_W'(CMD_ALU_OP))  w_next = ST_ALU_OPA;
          else if (w_byte == DATA_W'(CMD_ALU_NOP)) w_next = ST_ALU_FUN;
          else                                     w_err  = 1'b1;
        end
        ST_WR_ADDR: begin
          w_addr = w_byte[ADDR_W-1:0];
          w_next = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          w_wr_en   = 1'b1;
          w_rf_addr = r_addr;
          w_wr_data = w_byte;
          w_next    = ST_IDLE;
        end
        ST_RD_ADDR: begin
          w_rd_en   = 1'b1;
          w_rf_addr = w_byte[ADDR_W-1:0];
          w_next    = ST_IDLE;
        end
        ST_ALU_OPA: begin
          w_wr_en   = 1'b1;
          w_rf_addr = ADDR_W'(OPA_ADDR);
          w_wr_data = w_byte;
          w_next    = ST_ALU_OPB;
        end
        ST_ALU_OPB: begin
          w_wr_en   = 1'b1;
          w_rf_addr = ADDR_W'(OPB_ADDR);
          w_wr_data = w_byte;
          w_next    = ST_ALU_FUN;
        end
        ST_ALU_FUN: begin
          w_alu_en  = 1'b1;
          w_alu_fun = w_byte[FUN_W-1:0];
          w_next    = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end else if (w_expire) begin
      w_next = ST_IDLE;
      w_err  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_rf_addr <= '0;
      r_wr_data <= '0;
      r_alu_fun <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_addr    <= w_addr;
      r_rf_addr <= w_rf_addr;
      r_wr_data <= w_wr_data;
      r_alu_fun <= w_alu_fun;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_alu_en  <= w_alu_en;
      r_err     <= w_err;
      r_busy    <= (w_next != ST_IDLE);
    end
  end

  assign bus.RF_WrEn    = r_wr_en;
  assign bus.RF_RdEn    = r_rd_en;
  assign bus.RF_Address = r_rf_addr;
  assign bus.RF_WrData  = r_wr_data;
  assign bus.ALU_EN     = r_alu_en;
  assign bus.ALU_FUN    = r_alu_fun;
  assign bus.BUSY       = r_busy;
  assign bus.CMD_ERR    = r_err;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frames plus random byte streams checked
// cycle by cycle against a frame-buffer reference model.
module tb_uart_rx_cmd_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FUN_W  = 4;
`ifdef CMD_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 2048;
`endif

  logic CLK;
  logic RST;
  int   n_chk;
  int   n_fail;

  uart_rx_cmd_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W)) bus ();

  uart_rx_cmd_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: bytes of the frame in progress plus last-issued output values
  logic [7:0]        frame [$];
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic [FUN_W-1:0]  m_fun;
  int                m_idle;

  task automatic model_reset();
    frame.delete();
    m_addr  = '0;
    m_wdata = '0;
    m_fun   = '0;
    m_idle  = 0;
  endtask

  // {wr, rd, addr, wdata, alu_en, fun, busy, err}
  task automatic step(input logic v, input logic [7:0] d,
                      output logic [20:0] exp, output logic [20:0] obs);
    logic wr, rd, al, err, done;
    int   n;
    wr = 0; rd = 0; al = 0; err = 0; done = 0;
    @(negedge CLK);
    bus.RX_D_VLD  = v;
    bus.RX_P_DATA = d;
    if (v) begin
      m_idle = 0;
      frame.push_back(d);
      n = frame.size();
      case (frame[0])
        8'hAA: if (n == 3) begin
          wr = 1; m_addr = frame[1][ADDR_W-1:0]; m_wdata = frame[2]; done = 1;
        end
        8'hBB: if (n == 2) begin
          rd = 1; m_addr = frame[1][ADDR_W-1:0]; done = 1;
        end
        8'hCC: begin
          if (n == 2) begin wr = 1; m_addr = 0; m_wdata = frame[1]; end
          if (n == 3) begin wr = 1; m_addr = 1; m_wdata = frame[2]; end
          if (n == 4) begin al = 1; m_fun = frame[3][FUN_W-1:0]; done = 1; end
        end
        8'hDD: if (n == 2) begin
          al = 1; m_fun = frame[1][FUN_W-1:0]; done = 1;
        end
        default: begin err = 1; done = 1; end
      endcase
      if (done) frame.delete();
    end else if (frame.size() != 0) begin
      m_idle++;
`ifdef CMD_TIMEOUT_EN
      if (m_idle == TO) begin
        err = 1;
        frame.delete();
        m_idle = 0;
      end
`endif
    end
    exp = {wr, rd, m_addr, m_wdata, al, m_fun, frame.size() != 0, err};
    @(posedge CLK);
    #1;
    obs = {bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData,
           bus.ALU_EN, bus.ALU_FUN, bus.BUSY, bus.CMD_ERR};
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    bus.RX_D_VLD  = 0;
    bus.RX_P_DATA = 0;
    RST = 1'b1;
    #2 RST = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    obs = {bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData,
           bus.ALU_EN, bus.ALU_FUN, bus.BUSY, bus.CMD_ERR};
    n_chk++;
    if (obs !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 21'h0);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // bit 8 = valid; gaps exercise the hold behaviour
  task automatic test_rf_write();
    logic [8:0]  s [7] = '{9'h1AA, 9'h000, 9'h105, 9'h000, 9'h000, 9'h13C, 9'h000};
    logic [20:0] exp, obs;
    for (int i = 0; i < 7; i++) begin
      step(s[i][8], s[i][7:0], exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rf_write step %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_rf_read();
    logic [8:0]  s [4] = '{9'h1BB, 9'h10F, 9'h000, 9'h000};
    logic [20:0] exp, obs;
    for (int i = 0; i < 4; i++) begin
      step(s[i][8], s[i][7:0], exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rf_read step %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  // Unknown byte, then ALU-no-operand frame; upper function bits ignored
  task automatic test_unknown_nop();
    logic [8:0]  s [6] = '{9'h155, 9'h000, 9'h1DD, 9'h000, 9'h1F7, 9'h000};
    logic [20:0] exp, obs;
    for (int i = 0; i < 6; i++) begin
      step(s[i][8], s[i][7:0], exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL unknown_nop step %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  // Consecutive-cycle bytes; mid-frame command codes are payload
  task automatic test_back_to_back();
    logic [8:0]  s [10] = '{9'h1CC, 9'h112, 9'h134, 9'h102, 9'h1BB, 9'h1AA,
                            9'h1AA, 9'h1E9, 9'h1CC, 9'h000};
    logic [20:0] exp, obs;
    for (int i = 0; i < 10; i++) begin
      step(s[i][8], s[i][7:0], exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [20:0] exp, obs;
    step(1, 8'hAA, exp, obs);
    step(1, 8'h03, exp, obs);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL midframe_pre: got %h expected %h", obs, exp);
    end
    @(negedge CLK);
    bus.RX_D_VLD = 0;
    RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    obs = {bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData,
           bus.ALU_EN, bus.ALU_FUN, bus.BUSY, bus.CMD_ERR};
    n_chk++;
    if (obs !== 21'h0) begin
      n_fail++;
      $display("FAIL midframe_rst: got %h expected %h", obs, 21'h0);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 8'h99, exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL midframe_post step %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    logic [20:0] exp, obs;
    for (int i = 0; i < 24; i++) begin
      step(i < 2, (i == 0) ? 8'hCC : 8'h11, exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL timeout step %0d: got %h expected %h", i, obs, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(i < 2, (i == 0) ? 8'hDD : 8'h01, exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL timeout_after step %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [20:0] exp, obs;
    logic [7:0]  d;
    logic        v;
    logic [7:0]  cmds [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 1) == 0) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
      step(v, d, exp, obs);
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_rf_write();
    test_rf_read();
    test_unknown_nop();
    test_back_to_back();
    test_reset_midframe();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
